gf22_ti_mul_sched: RTL

Time-multiplexed scheduler that shares one 2-share GF(2^2) scaling-multiplier core among NREQ requesters inside the masked S-box datapath. It arbitrates round-robin and evaluates the four share cross-products serially over four cycles, one product per cycle, to preserve non-completeness. It then emits a re-masked 2-share result using a fresh 2-bit mask.

---
 rtl/gf22_ti_mul_sched_pkg.sv | 22 ++
 rtl/gf22_ti_mul_sched_arb.sv | 38 +++
 rtl/gf22_ti_mul_sched_mul.sv | 12 +
 rtl/gf22_ti_mul_sched.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/gf22_ti_mul_sched_pkg.sv
// Shared types and constants for the time-multiplexed GF(2^2) masked multiplier scheduler.
package gf22_ti_mul_sched_pkg;

   localparam int NREQ_DEF = 4;
   localparam int SW       = 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_P00  = 3'd1,
      S_P01  = 3'd2,
      S_P10  = 3'd3,
      S_P11  = 3'd4,
      S_DONE = 3'd5
   } state_e;

   // Polynomial basis x^2+x+1; the scaling constant folds to 1 in this basis.
   function automatic logic [SW-1:0] gf22_mul(input logic [SW-1:0] x, input logic [SW-1:0] y);
      gf22_mul = {(x[1] & y[1]) ^ (x[1] & y[0]) ^ (x[0] & y[1]),
                  (x[1] & y[1]) ^ (x[0] & y[0])};
   endfunction

endpackage

// File: rtl/gf22_ti_mul_sched_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo NREQ.
module rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [IDW:0]   sum;
   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr_i} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
         end
         cand = sum[IDW-1:0];
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/gf22_ti_mul_sched_mul.sv
// Shared GF(2^2) scaling-multiplier core; purely combinational, one share pair per use.
module gf22mul_scaling
   import gf22_ti_mul_sched_pkg::*;
(
   input  logic [SW-1:0] x_i,
   input  logic [SW-1:0] y_i,
   output logic [SW-1:0] p_o
);

   assign p_o = gf22_mul(x_i, y_i);

endmodule

// File: rtl/gf22_ti_mul_sched.sv
// Round-robin scheduler sharing one GF(2^2) multiplier; four serial cross-products, re-masked 2-share result.
module gf22_ti_mul_sched
   import gf22_ti_mul_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = 2
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic [NREQ-1:0]    req,
   input  logic [SW*NREQ-1:0] a0,
   input  logic [SW*NREQ-1:0] a1,
   input  logic [SW*NREQ-1:0] b0,
   input  logic [SW*NREQ-1:0] b1,
   input  logic [SW-1:0]      rnd,
   output logic [NREQ-1:0]    gnt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDW-1:0]     out_id,
   output logic [SW-1:0]      z0,
   output logic [SW-1:0]      z1
);

   state_e         state_q;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [SW-1:0]  a0_q, a1_q, b0_q, b1_q;
   logic [SW-1:0]  acc0_q, acc1_q;
   logic [SW-1:0]  z0_q, z1_q;
   logic [IDW-1:0] out_id_q;
   logic           out_valid_q;

   logic [SW-1:0]  a0_arr [NREQ];
   logic [SW-1:0]  a1_arr [NREQ];
   logic [SW-1:0]  b0_arr [NREQ];
   logic [SW-1:0]  b1_arr [NREQ];

   logic [NREQ-1:0] arb_gnt;
   logic [IDW-1:0]  arb_idx;
   logic            arb_any;
   logic [SW-1:0]   mul_x, mul_y, prod;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a0_arr[gi] = a0[gi*SW +: SW];
         assign a1_arr[gi] = a1[gi*SW +: SW];
         assign b0_arr[gi] = b0[gi*SW +: SW];
         assign b1_arr[gi] = b1[gi*SW +: SW];
      end
   endgenerate

   rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   assign ptr_d = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + 1'b1;

   // Only latched shares reach the core; the state selects exactly one (ax, by) pair.
   always_comb begin
      mul_x = a1_q;
      mul_y = b1_q;
      if (state_q == S_P00 || state_q == S_P01) mul_x = a0_q;
      if (state_q == S_P00 || state_q == S_P10) mul_y = b0_q;
   end

   gf22mul_scaling u_mul (
      .x_i (mul_x),
      .y_i (mul_y),
      .p_o (prod)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         a0_q        <= '0;
         a1_q        <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         acc0_q      <= '0;
         acc1_q      <= '0;
         z0_q        <= '0;
         z1_q        <= '0;
         out_id_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arb_any) begin
                  a0_q     <= a0_arr[arb_idx];
                  a1_q     <= a1_arr[arb_idx];
                  b0_q     <= b0_arr[arb_idx];
                  b1_q     <= b1_arr[arb_idx];
                  acc0_q   <= rnd;
                  acc1_q   <= rnd;
                  out_id_q <= arb_idx;
                  ptr_q    <= ptr_d;
                  state_q  <= S_P00;
               end
            end
            S_P00: begin
               acc0_q  <= acc0_q ^ prod;
               state_q <= S_P01;
            end
            S_P01: begin
               acc0_q  <= acc0_q ^ prod;
               state_q <= S_P10;
            end
            S_P10: begin
               acc1_q  <= acc1_q ^ prod;
               state_q <= S_P11;
            end
            S_P11: begin
               acc1_q      <= acc1_q ^ prod;
               z0_q        <= acc0_q;
               z1_q        <= acc1_q ^ prod;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  z0_q        <= '0;
                  z1_q        <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Reset also masks the combinational grant so nothing is offered while held in reset.
   assign gnt       = (RSTn && state_q == S_IDLE) ? arb_gnt : '0;
   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign z0        = z0_q;
   assign z1        = z1_q;

endmodule
